// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one physical memory port between the LC-3b
// instruction-fetch requester (i_*) and the data load/store requester (d_*).
//
// One access is in flight at a time. In IDLE a pending request is granted,
// its op/address/write data/byte mask are captured, and the FSM moves to
// SERVE_I or SERVE_D. While serving, the pmem_* outputs come only from the
// captured copy, so requester inputs may change freely. pmem_resp completes
// the access: the granted port's resp pulses in that same cycle, pmem_rdata
// is forwarded to both rdata outputs, and the FSM returns to IDLE.
// This always leaves one idle cycle between consecutive grants.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_mem_read/address          instruction fetch request (read only)
//   i_mem_rdata/resp            instruction fetch completion
//   d_mem_read/write            data request (read+write together = write)
//   d_mem_byte_enable/address/wdata   data request payload
//   d_mem_rdata/resp            data access completion
//   pmem_read/write/byte_enable/address/wdata   physical port request
//   pmem_rdata/resp             physical port completion
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> a tie goes to the port not granted last
//                       undefined -> fixed priority, data port wins ties
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [1:0]        d_mem_byte_enable,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [1:0]        pmem_byte_enable,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic              d_req;
    logic              d_is_write;
    logic              grant_i;
    logic              grant_d;

    // Captured copy of the granted request.
    logic              op_write_lat;
    logic [1:0]        be_lat;
    logic [ADDR_W-1:0] addr_lat;
    logic [DATA_W-1:0] wdata_lat;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the data port received the most recent grant.
    logic              last_grant_d;
`endif

    assign d_req      = d_mem_read | d_mem_write;
    // A simultaneous read and write strobe is served as a write.
    assign d_is_write = d_mem_write;

    // Read data is simply forwarded; only resp tells a port it is theirs.
    assign i_mem_rdata = pmem_rdata;
    assign d_mem_rdata = pmem_rdata;

    assign pmem_byte_enable = be_lat;
    assign pmem_address     = addr_lat;
    assign pmem_wdata       = wdata_lat;

    always_comb begin
        state_nxt  = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_mem_resp = 1'b0;
        d_mem_resp = 1'b0;

        case (state)
            IDLE: begin
                // pmem_resp is deliberately ignored here: a late response for
                // an access aborted by reset must not complete anything.
                if (d_req && i_mem_read) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (last_grant_d) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
`else
                    grant_d = 1'b1;
`endif
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (i_mem_read) begin
                    grant_i = 1'b1;
                end

                if (grant_d) begin
                    state_nxt = SERVE_D;
                end else if (grant_i) begin
                    state_nxt = SERVE_I;
                end
            end

            SERVE_I: begin
                pmem_read  = ~op_write_lat;
                pmem_write = op_write_lat;
                if (pmem_resp) begin
                    // Gated by rst_n so a reset cycle never reports completion.
                    i_mem_resp = rst_n;
                    state_nxt  = IDLE;
                end
            end

            SERVE_D: begin
                pmem_read  = ~op_write_lat;
                pmem_write = op_write_lat;
                if (pmem_resp) begin
                    d_mem_resp = rst_n;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_write_lat <= 1'b0;
            be_lat       <= 2'b00;
            addr_lat     <= '0;
            wdata_lat    <= '0;
        end else if (grant_d) begin
            op_write_lat <= d_is_write;
            be_lat       <= d_is_write ? d_mem_byte_enable : 2'b11;
            addr_lat     <= d_mem_address;
            wdata_lat    <= d_mem_wdata;
        end else if (grant_i) begin
            op_write_lat <= 1'b0;
            be_lat       <= 2'b11;
            addr_lat     <= i_mem_address;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_d <= 1'b0;
        end else if (grant_d) begin
            last_grant_d <= 1'b1;
        end else if (grant_i) begin
            last_grant_d <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed request vectors with expected physical-port
// activity and completions, plus hand sequences for mid-access input change,
// mid-access reset and continuously contending requesters.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic [15:0] i_mem_rdata;
    logic        i_mem_resp;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic [15:0] d_mem_rdata;
    logic        d_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_mem_read       (i_mem_read),
        .i_mem_address    (i_mem_address),
        .i_mem_rdata      (i_mem_rdata),
        .i_mem_resp       (i_mem_resp),
        .d_mem_read       (d_mem_read),
        .d_mem_write      (d_mem_write),
        .d_mem_byte_enable(d_mem_byte_enable),
        .d_mem_address    (d_mem_address),
        .d_mem_wdata      (d_mem_wdata),
        .d_mem_rdata      (d_mem_rdata),
        .d_mem_resp       (d_mem_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        i_rd;
        logic        d_rd;
        logic        d_wr;
        logic [15:0] i_addr;
        logic [15:0] d_addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          waits;
        logic [15:0] rdata;
        logic        exp_d;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [1:0]  exp_be;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic i_rd, logic d_rd, logic d_wr,
                                logic [15:0] i_addr, logic [15:0] d_addr,
                                logic [1:0] be, logic [15:0] wdata, int waits,
                                logic [15:0] rdata, logic exp_d, logic exp_wr,
                                logic [15:0] exp_addr, logic [1:0] exp_be);
        vec_t v;
        v.i_rd = i_rd;   v.d_rd = d_rd;     v.d_wr = d_wr;
        v.i_addr = i_addr; v.d_addr = d_addr;
        v.be = be;       v.wdata = wdata;   v.waits = waits;
        v.rdata = rdata; v.exp_d = exp_d;   v.exp_wr = exp_wr;
        v.exp_addr = exp_addr; v.exp_be = exp_be;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Requests must already be driven with the DUT in IDLE. Covers the grant
    // edge, the wait cycles, the completion cycle and the following IDLE cycle.
    task automatic serve(string tag, logic exp_d, logic exp_wr,
                         logic [15:0] exp_addr, logic [1:0] exp_be,
                         logic [15:0] exp_wdata, int waits,
                         logic [15:0] rdata, bit drop);
        @(posedge clk); #1;
        chk({tag, ".pmem_read"},  {31'd0, pmem_read},  {31'd0, ~exp_wr});
        chk({tag, ".pmem_write"}, {31'd0, pmem_write}, {31'd0, exp_wr});
        chk({tag, ".pmem_address"}, {16'd0, pmem_address}, {16'd0, exp_addr});
        chk({tag, ".pmem_byte_enable"}, {30'd0, pmem_byte_enable}, {30'd0, exp_be});
        if (exp_wr) chk({tag, ".pmem_wdata"}, {16'd0, pmem_wdata}, {16'd0, exp_wdata});
        for (int w = 0; w < waits; w++) begin
            chk({tag, ".wait_resp"}, {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
            @(posedge clk); #1;
            chk({tag, ".wait_strobe"}, {31'd0, pmem_read | pmem_write}, 32'd1);
        end
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        chk({tag, ".i_mem_resp"}, {31'd0, i_mem_resp}, {31'd0, ~exp_d});
        chk({tag, ".d_mem_resp"}, {31'd0, d_mem_resp}, {31'd0, exp_d});
        if (!exp_wr)
            chk({tag, ".rdata"}, {16'd0, exp_d ? d_mem_rdata : i_mem_rdata}, {16'd0, rdata});
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        if (drop) begin
            if (exp_d) begin
                d_mem_read  = 1'b0;
                d_mem_write = 1'b0;
            end else begin
                i_mem_read = 1'b0;
            end
        end
        #1;
        chk({tag, ".idle_strobes"}, {30'd0, pmem_read, pmem_write}, 32'd0);
        chk({tag, ".idle_resp"}, {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
    endtask

    initial begin
        logic exp_seq;

        rst_n = 1'b0;
        i_mem_read = 1'b0;  i_mem_address = '0;
        d_mem_read = 1'b0;  d_mem_write = 1'b0;
        d_mem_byte_enable = '0; d_mem_address = '0; d_mem_wdata = '0;
        pmem_rdata = '0;    pmem_resp = 1'b0;

        // Lone fetch, byte store, data read, read+write collision, then ties.
        vecs[0] = mk(1, 0, 0, 16'h0040, 16'h0000, 2'b00, 16'h0000, 3, 16'h1234,
                     0, 0, 16'h0040, 2'b11);
        vecs[1] = mk(0, 0, 1, 16'h0000, 16'h0101, 2'b10, 16'hAB00, 0, 16'h5555,
                     1, 1, 16'h0101, 2'b10);
        vecs[2] = mk(0, 1, 0, 16'h0000, 16'h0300, 2'b01, 16'h0000, 1, 16'hBEEF,
                     1, 0, 16'h0300, 2'b11);
        vecs[3] = mk(0, 1, 1, 16'h0000, 16'h0400, 2'b01, 16'h00CD, 0, 16'h0000,
                     1, 1, 16'h0400, 2'b01);
        // Before every tie the data port holds the last grant, so round-robin
        // picks I; fixed priority picks D. The loser then goes alone.
        for (int k = 0; k < 3; k++) begin
            logic [15:0] ia;
            logic [15:0] da;
            ia = 16'h0500 + 16'(k);
            da = 16'h0600 + 16'(k);
            if (RR) begin
                vecs[4 + 2*k] = mk(1, 1, 0, ia, da, 2'b11, 16'h0, k, 16'h2000 + 16'(k),
                                   0, 0, ia, 2'b11);
                vecs[5 + 2*k] = mk(0, 1, 0, ia, da, 2'b11, 16'h0, 0, 16'h3000 + 16'(k),
                                   1, 0, da, 2'b11);
            end else begin
                vecs[4 + 2*k] = mk(1, 1, 0, ia, da, 2'b11, 16'h0, k, 16'h2000 + 16'(k),
                                   1, 0, da, 2'b11);
                vecs[5 + 2*k] = mk(1, 0, 0, ia, da, 2'b11, 16'h0, 0, 16'h3000 + 16'(k),
                                   0, 0, ia, 2'b11);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset.pmem_read",  {31'd0, pmem_read},  32'd0);
        chk("reset.pmem_write", {31'd0, pmem_write}, 32'd0);
        chk("reset.pmem_byte_enable", {30'd0, pmem_byte_enable}, 32'd0);
        chk("reset.pmem_address", {16'd0, pmem_address}, 32'd0);
        chk("reset.pmem_wdata", {16'd0, pmem_wdata}, 32'd0);
        chk("reset.resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Response while idle must do nothing.
        pmem_resp = 1'b1;
        #1;
        chk("idle_resp.resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("idle_resp.strobes", {30'd0, pmem_read, pmem_write}, 32'd0);

        for (int v = 0; v < 10; v++) begin
            i_mem_read        = vecs[v].i_rd;
            i_mem_address     = vecs[v].i_addr;
            d_mem_read        = vecs[v].d_rd;
            d_mem_write       = vecs[v].d_wr;
            d_mem_address     = vecs[v].d_addr;
            d_mem_byte_enable = vecs[v].be;
            d_mem_wdata       = vecs[v].wdata;
            serve($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_wr,
                  vecs[v].exp_addr, vecs[v].exp_be, vecs[v].wdata,
                  vecs[v].waits, vecs[v].rdata, 1'b1);
        end

        // Data address changes while the access is in flight.
        d_mem_read = 1'b1;
        d_mem_address = 16'h0010;
        @(posedge clk); #1;
        chk("chg.pmem_read", {31'd0, pmem_read}, 32'd1);
        d_mem_address = 16'h0020;
        for (int w = 0; w < 2; w++) begin
            #1;
            chk("chg.pmem_address", {16'd0, pmem_address}, 32'h0010);
            @(posedge clk); #1;
        end
        chk("chg.pmem_address_late", {16'd0, pmem_address}, 32'h0010);
        pmem_rdata = 16'h7777;
        pmem_resp = 1'b1;
        #1;
        chk("chg.d_mem_resp", {31'd0, d_mem_resp}, 32'd1);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        d_mem_read = 1'b0;
        #1;
        chk("chg.idle", {30'd0, pmem_read, pmem_write}, 32'd0);

        // Reset during SERVE_I, then a stale response.
        i_mem_read = 1'b1;
        i_mem_address = 16'h0200;
        @(posedge clk); #1;
        chk("rst.pmem_read", {31'd0, pmem_read}, 32'd1);
        chk("rst.pmem_address", {16'd0, pmem_address}, 32'h0200);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_mem_read = 1'b0;
        #1;
        chk("rst.strobes", {30'd0, pmem_read, pmem_write}, 32'd0);
        chk("rst.pmem_address_clr", {16'd0, pmem_address}, 32'd0);
        pmem_resp = 1'b1;
        #1;
        chk("rst.stale_resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("rst.stale_strobes", {30'd0, pmem_read, pmem_write}, 32'd0);

        // Both requesters held high across four grants, starting after reset.
        i_mem_read = 1'b1;
        i_mem_address = 16'h0700;
        d_mem_read = 1'b1;
        d_mem_address = 16'h0800;
        for (int k = 0; k < 4; k++) begin
            exp_seq = RR ? ((k % 2) == 0) : 1'b1;
            serve($sformatf("cont%0d", k), exp_seq, 1'b0,
                  exp_seq ? 16'h0800 : 16'h0700, 2'b11, 16'h0,
                  k % 2, 16'h1000 + 16'(k), 1'b0);
            if (k == 3) begin
                i_mem_read = 1'b0;
                d_mem_read = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("cont.final_idle", {30'd0, pmem_read, pmem_write}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single physical memory port between the instruction-fetch requester and the data (load/store) requester of the LC-3b datapath. It serialises their read/write/resp handshakes onto one port and returns each response only to the port that issued the request. It sits between the control/datapath pair and physical memory, and is the enabling block for split I/D request paths and later cache insertion.

## Interface
- ADDR_W, 16, address width in bits
- DATA_W, 16, data word width in bits
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_mem_read  in  1  instruction read request; held until i_mem_resp
- i_mem_address  in  ADDR_W  instruction address
- i_mem_rdata  out  DATA_W  instruction read data, valid with i_mem_resp
- i_mem_resp  out  1  instruction access complete, one cycle
- d_mem_read  in  1  data read request; held until d_mem_resp
- d_mem_write  in  1  data write request; held until d_mem_resp
- d_mem_byte_enable  in  2  write byte mask (bit0 low byte, bit1 high byte)
- d_mem_address  in  ADDR_W  data address
- d_mem_wdata  in  DATA_W  data write data
- d_mem_rdata  out  DATA_W  data read data, valid with d_mem_resp
- d_mem_resp  out  1  data access complete, one cycle
- pmem_read / pmem_write  out  1 each  physical memory strobes
- pmem_byte_enable  out  2  physical byte mask
- pmem_address  out  ADDR_W  physical address
- pmem_wdata  out  DATA_W  physical write data
- pmem_rdata  in  DATA_W  physical read data
- pmem_resp  in  1  physical access complete

## Operation
- States: IDLE, SERVE_I, SERVE_D. Reset → IDLE.
- IDLE: when any request is present, grant one port, latch its op/address/wdata/byte mask into internal registers, and move to SERVE_I or SERVE_D. Stay in IDLE when no request is present.
- If only one port requests, that port is granted. If both request, the tie-break is set by the configuration macro (see Configuration).
- SERVE_x: pmem_* are driven only from the latched registers. Requester inputs are ignored while serving.
- On pmem_resp, pulse the granted port's resp, forward pmem_rdata to both rdata outputs, and return to IDLE.
- The ungranted port's resp stays 0 throughout.
- If d_mem_read and d_mem_write are both high, the access is treated as a write.
- For reads, pmem_byte_enable = 2'b11. For writes, it equals the latched d_mem_byte_enable.
- In IDLE, pmem_read = pmem_write = 0 and pmem_resp is ignored: no resp is generated and the state does not change.
- Reset values: state IDLE; pmem_read/pmem_write 0; pmem_byte_enable 2'b00; pmem_address 0; pmem_wdata 0; i_mem_resp/d_mem_resp 0; last-grant register = I.

## Timing
- Request high in IDLE at cycle N → pmem strobe high from cycle N+1.
- pmem_resp at cycle M → port resp high combinationally in cycle M; state is IDLE at M+1.
- Minimum access: 2 cycles, assuming 0-wait memory, i.e. pmem_resp asserted in the first strobe cycle.
- There is one mandatory IDLE cycle between grants, so the pmem strobe drops for at least one cycle between accesses.
- Requesters must drop their request in the cycle after resp. A request still high in that IDLE cycle is treated as a new access.
- rst_n low during SERVE_x: the state goes to IDLE at the next edge and the strobes drop. Any later pmem_resp for the aborted access is discarded.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the port not granted last. last_grant is updated on every grant, so after reset the first tie goes to D.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, D always wins ties. The last_grant register is not implemented.

## Test plan
- Lone fetch: i_mem_read=1, address 16'h0040; memory returns 16'h1234 after 3 wait cycles → pmem_read high with address 16'h0040; i_mem_resp pulses once with i_mem_rdata=16'h1234; d_mem_resp stays 0.
- Byte store: d_mem_write=1, address 16'h0101, byte mask 2'b10, wdata 16'hAB00 → pmem_write with byte_enable 2'b10 and wdata 16'hAB00; d_mem_resp pulses once; state is IDLE the next cycle.
- Tie, fixed priority (macro undefined): both ports request in the same cycle, repeated 3 times → D served first each time, I served after D completes.
- Tie, round-robin (macro defined), both ports requesting continuously → grants alternate D, I, D, I.
- Input change while serving: d_mem_address changes from 16'h0010 to 16'h0020 during SERVE_D → pmem_address stays 16'h0010 until resp.
- Mid-access reset: rst_n low during SERVE_I with no pmem_resp yet → IDLE next cycle, strobes 0; a pmem_resp arriving after reset produces no i_mem_resp or d_mem_resp.
